// File: rtl/tt_um_ternary_mac.sv
// Ternary-weight matrix-vector MAC: y = W*x with W snapshotted at start,
// activations streamed in one per beat, results streamed out one per beat.
module tt_um_ternary_mac #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int WIDTH       = 2,
    parameter int DATA_W      = 8,
    parameter int ACC_W       = DATA_W + $clog2(MAX_IN_LEN)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0]   ui_weights,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_W-1:0]                         in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ACC_W-1:0]                          out_data,
    output logic [$clog2(MAX_OUT_LEN)-1:0]            out_idx,
    output logic                                      busy,
    output logic                                      done
);

    localparam int IN_CW  = $clog2(MAX_IN_LEN);
    localparam int OUT_CW = $clog2(MAX_OUT_LEN);
    localparam int ROW_W  = WIDTH * MAX_OUT_LEN;
    localparam int W_BITS = ROW_W * MAX_IN_LEN;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [W_BITS-1:0]         r_weights;
    logic signed [ACC_W-1:0]   r_acc [MAX_OUT_LEN];
    logic [IN_CW-1:0]          r_in_cnt;
    logic [OUT_CW-1:0]         r_out_cnt;
    logic                      r_done;

    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_last_in;
    logic                      w_last_out;
    logic signed [ACC_W-1:0]   w_x_ext;
    logic [ROW_W-1:0]          w_row;
    logic [MAX_OUT_LEN-1:0]    w_plus;
    logic [MAX_OUT_LEN-1:0]    w_minus;

    assign w_in_fire  = (r_state == ACCUM) && in_valid;
    assign w_out_fire = (r_state == DRAIN) && out_ready;
    assign w_last_in  = (r_in_cnt == IN_CW'(MAX_IN_LEN - 1));
    assign w_last_out = (r_out_cnt == OUT_CW'(MAX_OUT_LEN - 1));
    assign w_x_ext    = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign w_row      = r_weights[int'(r_in_cnt)*ROW_W +: ROW_W];

    // 01 adds, 11 subtracts; 00 and 10 both leave the accumulator alone.
    always_comb begin
        w_plus  = '0;
        w_minus = '0;
        for (int j = 0; j < MAX_OUT_LEN; j++) begin
            w_plus[j]  = (w_row[j*WIDTH +: WIDTH] == WIDTH'(1));
            w_minus[j] = (w_row[j*WIDTH +: WIDTH] == WIDTH'(3));
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)                    w_next = ACCUM;
            ACCUM:   if (w_in_fire && w_last_in)   w_next = DRAIN;
            DRAIN:   if (w_out_fire && w_last_out) w_next = IDLE;
            default:                               w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_weights <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
            for (int j = 0; j < MAX_OUT_LEN; j++) r_acc[j] <= '0;
        end else begin
            r_done <= w_out_fire && w_last_out;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_weights <= ui_weights;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        for (int j = 0; j < MAX_OUT_LEN; j++) r_acc[j] <= '0;
                    end
                end
                ACCUM: begin
                    if (w_in_fire) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        for (int j = 0; j < MAX_OUT_LEN; j++) begin
                            if (w_plus[j])       r_acc[j] <= r_acc[j] + w_x_ext;
                            else if (w_minus[j]) r_acc[j] <= r_acc[j] - w_x_ext;
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result mux reads registers only, so it holds steady under backpressure.
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DRAIN);
    assign out_data  = out_valid ? r_acc[r_out_cnt] : '0;
    assign out_idx   = r_out_cnt;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// Self-checking bench for tt_um_ternary_mac: table-driven jobs plus
// backpressure, back-to-back and mid-job reset sequences, scoreboard checked.
module tb_tt_um_ternary_mac;

    localparam int NI = 16;
    localparam int NO = 8;
    localparam int WB = 2 * NI * NO;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WB-1:0] ui_weights;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [11:0]   out_data;
    logic [2:0]    out_idx;
    logic          busy;
    logic          done;

    tt_um_ternary_mac dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ui_weights (ui_weights),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    typedef struct {
        int    wMode;
        int    xMode;
        int    expY;
        string name;
    } vec_t;

    exp_t              expQ[$];
    vec_t              tbl[5];
    logic [WB-1:0]     wVec;
    logic signed [7:0] xVec [NI];
    int                checks    = 0;
    int                failures  = 0;
    int                cyc       = 0;
    int                doneCount = 0;
    int                jobsDone  = 0;
    int                startCyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [1:0] codeFor(input int mode, input int i, input int j);
        case (mode)
            0:       return 2'b01;
            1:       return (i == j) ? 2'b01 : (i == j + 8) ? 2'b11 :
                            (((i + j) % 2) != 0) ? 2'b10 : 2'b00;
            2:       return 2'b11;
            3:       return 2'b10;
            default: return 2'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic buildW(input int mode);
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                wVec[(i*NO + j)*2 +: 2] = codeFor(mode, i, j);
    endtask

    task automatic buildX(input int mode);
        for (int i = 0; i < NI; i++) begin
            case (mode)
                0:       xVec[i] = 8'(i);
                1:       xVec[i] = 8'(5 * i);
                2:       xVec[i] = 8'(-128);
                3:       xVec[i] = 8'(127);
                default: xVec[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    function automatic int modelY(input int j);
        int                s;
        logic [1:0]        c;
        logic signed [11:0] t;
        s = 0;
        for (int i = 0; i < NI; i++) begin
            c = wVec[(i*NO + j)*2 +: 2];
            if (c == 2'b01)      s = s + int'(xVec[i]);
            else if (c == 2'b11) s = s - int'(xVec[i]);
        end
        t = 12'(s);
        return int'(t);
    endfunction

    // Result monitor: every accepted output beat is matched against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) doneCount++;
            if (!rst && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    check("unexpected result beat", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    check("out_idx", int'(out_idx), e.idx);
                    check($sformatf("y[%0d]", e.idx), int'($signed(out_data)), e.data);
                end
            end
        end
    end

    task automatic startJob();
        start      = 1'b1;
        ui_weights = wVec;
        @(posedge clk); #1;
        start    = 1'b0;
        startCyc = cyc;
        check("busy after start", int'(busy), 1);
        check("in_ready after start", int'(in_ready), 1);
    endtask

    task automatic applyStimulus(input int nBeats, input int gapMax, input bit pokeStart,
                                 input bit swapW, input bit useConst, input int constY);
        bit hs;
        int t;
        int n;
        for (int j = 0; j < NO; j++) expQ.push_back('{j, useConst ? constY : modelY(j)});
        startJob();
        if (swapW) ui_weights = ~wVec;
        for (int i = 0; i < nBeats; i++) begin
            if (gapMax > 0) begin
                in_valid = 1'b0;
                n = $urandom_range(0, gapMax);
                repeat (n) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_data  = xVec[i];
            if (pokeStart && i == 4) begin
                start      = 1'b1;
                ui_weights = ~wVec;
            end
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 50) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk); #1;
                t++;
            end
            start = 1'b0;
            if (!hs) begin
                check("input handshake timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input int stallAt, input bit pokeStart, input bit timing);
        bit stalled;
        bit poked;
        int t;
        int expData;
        stalled   = 1'b0;
        poked     = 1'b0;
        t         = 0;
        out_ready = 1'b1;
        while (!done && t < 200) begin
            if (stallAt >= 0 && !stalled && out_valid && int'(out_idx) == stallAt) begin
                stalled   = 1'b1;
                expData   = (expQ.size() > 0) ? expQ[0].data : 0;
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("stall out_valid", int'(out_valid), 1);
                    check("stall out_idx", int'(out_idx), stallAt);
                    check("stall out_data", int'($signed(out_data)), expData);
                end
                out_ready = 1'b1;
            end
            if (pokeStart && !poked && out_valid && out_idx == 3'd5) begin
                poked      = 1'b1;
                start      = 1'b1;
                ui_weights = ~wVec;
            end
            @(posedge clk); #1;
            start = 1'b0;
            t++;
        end
        if (!done) begin
            check("done timeout", 0, 1);
        end else begin
            jobsDone++;
            check("busy in done cycle", int'(busy), 0);
            if (timing) check("done latency (edges after start)", cyc - startCyc, 24);
        end
        check("scoreboard drained", expQ.size(), 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{0, 0,   120,  "all +1, x=i"};
        tbl[1] = '{1, 1,   -40,  "diagonal, x=5i"};
        tbl[2] = '{0, 2,  -2048, "all +1, x=-128"};
        tbl[3] = '{2, 3,  -2032, "all -1, x=127"};
        tbl[4] = '{3, 0,     0,  "all 2'b10, x=i"};

        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        ui_weights = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset out_idx", int'(out_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Uniform-result jobs, run back to back with continuous ready.
        for (int k = 0; k < 5; k++) begin
            $display("[TB] table job %0d: %s", k, tbl[k].name);
            buildW(tbl[k].wMode);
            buildX(tbl[k].xMode);
            applyStimulus(NI, 0, 1'b0, 1'b0, 1'b1, tbl[k].expY);
            checkOutput(-1, 1'b0, 1'b1);
        end

        // Random job clean, then the same vectors with gaps, stall and disturbances.
        buildW(4);
        buildX(4);
        applyStimulus(NI, 0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput(-1, 1'b0, 1'b1);
        applyStimulus(NI, 3, 1'b1, 1'b1, 1'b0, 0);
        checkOutput(2, 1'b1, 1'b0);

        // Abort after five beats, then a fresh job must ignore the partial sums.
        buildW(0);
        buildX(3);
        applyStimulus(5, 0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        #1;
        check("abort in_ready", int'(in_ready), 0);
        check("abort out_valid", int'(out_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        buildX(0);
        applyStimulus(NI, 0, 1'b0, 1'b0, 1'b1, 120);
        checkOutput(-1, 1'b0, 1'b1);

        @(posedge clk); #1;
        check("done pulse count", doneCount, jobsDone);
        check("jobs completed", jobsDone, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
